i2c_eeprom_target: RTL and testbench

//  I2C target (slave) that emulates a byte-addressed EEPROM on the bus driven by our I2C initiator.

---
 rtl/i2c_eeprom_target.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_eeprom_target.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_target.sv
// I2C target that emulates a 2**AW-byte EEPROM: open-drain SDA, START/STOP tracking, write-commit strobe.
// Build option: define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on the synchronised SCL/SDA.
module i2c_eeprom_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned AW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // ---------------- bus front end ----------------
    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_c, sda_c;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_c;
        sda_prev_d = sda_c;
    end

    // Idle bus level is high, so reset the front end to 1 to avoid a phantom edge after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d;
    logic [1:0] sda_hist_q, sda_hist_d;
    logic       scl_flt_q, scl_flt_d;
    logic       sda_flt_q, sda_flt_d;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_flt_d  = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
        sda_flt_d  = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_flt_q  <= scl_flt_d;
            sda_flt_q  <= sda_flt_d;
        end
    end

    assign scl_c = scl_flt_q;
    assign sda_c = sda_flt_q;
`else
    assign scl_c = scl_sync_q[1];
    assign sda_c = sda_sync_q[1];
`endif

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c & scl_prev_q;
    assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    // ---------------- state and datapath registers ----------------
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_stb_q, wr_stb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          mem_we;
    logic [7:0]    mem_q [2**AW];
    logic [7:0]    rd_byte;

    assign rd_byte = mem_q[ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else if (scl_rise) begin
            if (state_q == RDATA_ACK && sda_c) state_d = IGNORE;
        end else if (scl_fall) begin
            case (state_q)
                ADDR:      if (bit_cnt_q == 4'd8)
                               state_d = (shift_q[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK:  state_d = rw_q ? RDATA : WADDR;
                WADDR:     if (bit_cnt_q == 4'd8) state_d = WADDR_ACK;
                WADDR_ACK: state_d = WDATA;
                WDATA:     if (bit_cnt_q == 4'd8) state_d = WDATA_ACK;
                WDATA_ACK: state_d = WDATA;
                RDATA:     if (bit_cnt_q == 4'd8) state_d = RDATA_ACK;
                RDATA_ACK: state_d = RDATA;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        if (stop_det) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, WADDR, WDATA: if (bit_cnt_q < 4'd8) begin
                    shift_d   = {shift_q[6:0], sda_c};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                // Pointer advances on every read byte, whether the initiator ACKs or NACKs.
                RDATA_ACK: ptr_d = ptr_q + 1'b1;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ADDR: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    if (shift_q[7:1] == DEV_ADDR) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        rw_d     = shift_q[0];
                    end
                end
                ADDR_ACK, RDATA_ACK: begin
                    if (state_q == RDATA_ACK || rw_q) begin
                        // First data bit goes out on the same fall that ends the ACK slot.
                        sda_oe_d  = ~rd_byte[7];
                        shift_d   = {rd_byte[6:0], 1'b0};
                        bit_cnt_d = 4'd1;
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
                WADDR: if (bit_cnt_q == 4'd8) begin
                    ptr_d     = shift_q[AW-1:0];
                    sda_oe_d  = 1'b1;
                    bit_cnt_d = 4'd0;
                end
                WDATA: if (bit_cnt_q == 4'd8) begin
                    mem_we    = 1'b1;
                    wr_stb_d  = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = shift_q;
                    ptr_d     = ptr_q + 1'b1;
                    sda_oe_d  = 1'b1;
                    bit_cnt_d = 4'd0;
                end
                WADDR_ACK, WDATA_ACK: sda_oe_d = 1'b0;
                RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end else begin
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // NOTE: the storage array has no reset; contents survive rst like a real EEPROM and it maps to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[ptr_q] <= shift_q;
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed + randomized bench for i2c_eeprom_target acting as bus initiator, with an array/pointer EEPROM model.
module tb_i2c_eeprom_target;
    localparam int AW = 4;
    localparam int Q  = 6;  // clocks per quarter SCL period

    logic          clk = 1'b0;
    logic          rst;
    logic          scl;
    logic          sda_drv;
    logic          sda_bus;
    logic          sda_oe;
    logic          busy;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_eeprom_target #(.DEV_ADDR(7'h50), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Monitor: logs committed writes and counts cycles with sda_oe / busy asserted.
    logic [11:0] stb_log [256];
    int          stb_n    = 0;
    int          oe_cnt   = 0;
    int          busy_cnt = 0;
    always @(negedge clk) begin
        if (wr_stb === 1'b1 && stb_n < 256) begin
            stb_log[stb_n] = {wr_addr, wr_data};
            stb_n++;
        end
        if (sda_oe === 1'b1) oe_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // Reference model: byte array plus word pointer.
    logic [7:0]    mem_m [2**AW];
    logic [AW-1:0] ptr_m = '0;
    logic [7:0]    data_buf [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_drv = b; wait_clk(Q);
        scl = 1'b1;  wait_clk(Q);
        s = sda_bus; wait_clk(Q);
        scl = 1'b0;  wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(nack, s);
    endtask

    task automatic write_txn(input logic [7:0] waddr, input int n, input string tag);
        logic        ack;
        int          s0;
        int          nacks;
        logic [11:0] exp_log [32];
        s0 = stb_n;
        nacks = 0;
        bus_start();
        write_byte(8'hA0, ack); if (ack !== 1'b0) nacks++;
        write_byte(waddr, ack); if (ack !== 1'b0) nacks++;
        ptr_m = waddr[AW-1:0];
        for (int i = 0; i < n; i++) begin
            write_byte(data_buf[i], ack); if (ack !== 1'b0) nacks++;
            exp_log[i]   = {ptr_m, data_buf[i]};
            mem_m[ptr_m] = data_buf[i];
            ptr_m        = ptr_m + 1'b1;
        end
        bus_stop();
        check({tag, " nacks"}, nacks, 0);
        check({tag, " stb_count"}, stb_n - s0, n);
        for (int i = 0; i < n && s0 + i < stb_n; i++)
            check($sformatf("%s stb%0d", tag, i), stb_log[s0 + i], exp_log[i]);
    endtask

    task automatic read_txn(input logic with_addr, input logic [7:0] waddr, input int n, input string tag);
        logic       ack;
        logic [7:0] b;
        int         nacks;
        nacks = 0;
        bus_start();
        if (with_addr) begin
            write_byte(8'hA0, ack); if (ack !== 1'b0) nacks++;
            write_byte(waddr, ack); if (ack !== 1'b0) nacks++;
            ptr_m = waddr[AW-1:0];
            bus_start();
        end
        write_byte(8'hA1, ack); if (ack !== 1'b0) nacks++;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            check($sformatf("%s byte%0d", tag, i), b, mem_m[ptr_m]);
            ptr_m = ptr_m + 1'b1;
        end
        bus_stop();
        check({tag, " nacks"}, nacks, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] gb;
        logic [7:0] g_exp;
        int         s0, o0, b0, n;
        logic [7:0] a;

        rst = 1'b1; scl = 1'b1; sda_drv = 1'b1;
        wait_clk(4);
        check("reset sda_oe", sda_oe, 0);
        check("reset busy", busy, 0);
        check("reset wr_stb", wr_stb, 0);
        check("reset wr_addr", wr_addr, 0);
        check("reset wr_data", wr_data, 0);
        rst = 1'b0;
        wait_clk(4 * Q);

        // Fill the whole array from a random start so every later read has a known value.
        for (int i = 0; i < 2**AW; i++) data_buf[i] = 8'($urandom);
        write_txn(8'($urandom_range(0, 255)), 2**AW, "fill");

        // Single-byte write.
        b0 = busy_cnt;
        data_buf[0] = 8'h5A;
        write_txn(8'h03, 1, "write1");
        check("write1 busy_seen", (busy_cnt > b0) ? 1 : 0, 1);
        check("write1 busy_after", busy, 0);

        // Random read with repeated START, then current-address read shows pointer at 4.
        read_txn(1'b1, 8'h03, 1, "read1");
        check("read1 ptr_model", ptr_m, 4);
        read_txn(1'b0, 8'h00, 1, "curread");

        // Burst across the top of the array.
        data_buf[0] = 8'h11; data_buf[1] = 8'h22; data_buf[2] = 8'h33;
        write_txn(8'h0E, 3, "wrap");
        check("wrap mem0_model", mem_m[0], 8'h33);
        read_txn(1'b1, 8'h0E, 3, "wrapread");

        // Randomized bursts.
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) data_buf[i] = 8'($urandom);
            write_txn(8'($urandom_range(0, 255)), n, $sformatf("rndw%0d", it));
            read_txn(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 6), $sformatf("rndr%0d", it));
        end

        // Address miss: no ACK, no busy, no writes.
        s0 = stb_n; o0 = oe_cnt; b0 = busy_cnt;
        bus_start();
        write_byte(8'hA2, ack); check("miss addr_nack", ack, 1);
        write_byte(8'h05, ack); check("miss waddr_nack", ack, 1);
        write_byte(8'h77, ack);
        bus_stop();
        check("miss oe_cycles", oe_cnt - o0, 0);
        check("miss busy_cycles", busy_cnt - b0, 0);
        check("miss stb_count", stb_n - s0, 0);

        // Abort after 4 data bits: no write, pointer stays at the word address.
        s0 = stb_n;
        bus_start();
        write_byte(8'hA0, ack); check("abort addr_ack", ack, 0);
        write_byte(8'h07, ack); check("abort waddr_ack", ack, 0);
        ptr_m = 4'h7;
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        bus_stop();
        check("abort stb_count", stb_n - s0, 0);
        check("abort sda_oe", sda_oe, 0);
        check("abort busy", busy, 0);
        read_txn(1'b0, 8'h00, 1, "abort_curread");
        data_buf[0] = 8'h99;
        write_txn(8'h08, 1, "after_abort");

        // One-clock low glitch on SCL during the high phase of data bit 4.
        gb = 8'($urandom);
`ifdef I2C_GLITCH_FILTER_EN
        g_exp = gb;
`else
        g_exp = {gb[7:4], gb[4], gb[3:1]};
`endif
        s0 = stb_n;
        bus_start();
        write_byte(8'hA0, ack); check("glitch addr_ack", ack, 0);
        write_byte(8'h09, ack); check("glitch waddr_ack", ack, 0);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) begin
                sda_drv = gb[i]; wait_clk(Q);
                scl = 1'b1;      wait_clk(Q);
                scl = 1'b0;      wait_clk(1);
                scl = 1'b1;      wait_clk(Q);
                scl = 1'b0;      wait_clk(Q);
            end else begin
                send_bit(gb[i], s);
            end
        end
        send_bit(1'b1, s);
        bus_stop();
        mem_m[9] = g_exp;
        ptr_m    = 4'hA;
        check("glitch stb_count", stb_n - s0, 1);
        if (stb_n > s0) check("glitch stb", stb_log[s0], {4'h9, g_exp});
        read_txn(1'b1, 8'h09, 1, "glitch_read");

        // Reset while the target is driving the address ACK.
        bus_start();
        a = 8'hA0;
        for (int i = 7; i >= 0; i--) send_bit(a[i], s);
        check("midrst ack_driven", sda_oe, 1);
        rst = 1'b1;
        wait_clk(1);
        check("midrst sda_oe", sda_oe, 0);
        check("midrst busy", busy, 0);
        ptr_m = '0;
        rst = 1'b0;
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(4 * Q);
        read_txn(1'b0, 8'h00, 1, "midrst_curread");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
